// File: rtl/grid_cursor_template.sv
// -----------------------------------------------------------------------------
// grid_cursor_template
//
// Purpose:
//   Produces per-pixel overlay flags for a COLS x ROWS grid of CELL_W x CELL_H
//   pixel cells placed on a 1024x768 visible area. The block reports whether
//   the current pixel is inside the grid, whether it lies on a grid line, and
//   the column/row of the cell under it. Column and row are tracked with
//   pixel-offset counters rather than dividers.
//
//   The block also owns the cursor position. Single-cycle button pulses move
//   it, and the WRAP parameter selects wrap-around or saturation at the grid
//   edges. The cursor highlight blinks with a half-period of BLINK_FRAMES
//   frames. BLINK_FRAMES = 0 keeps the highlight on.
//
//   All pixel flags are registered and describe the hc/vc pair presented one
//   clock earlier. Downstream logic delays HS/VS by one clock to match.
//
// Ports:
//   clk_vga      pixel clock
//   rst_n        asynchronous active-low reset
//   hc_visible   visible pixel column, 1-based; 0 during blanking
//   vc_visible   visible line number, 1-based; 0 during blanking
//   btn_up/down/left/right   one-cycle cursor move pulses
//   in_grid      pixel is inside the grid rectangle
//   lines        pixel is on a grid line (cell border or outer frame)
//   cell_x/y     column/row of the pixel's cell, 0 outside the grid
//   on_cursor    pixel is in the cursor cell interior and blink phase is on
//   cursor_x/y   cursor column/row
// -----------------------------------------------------------------------------
module grid_cursor_template #(
  parameter int GRID_XI      = 340,
  parameter int GRID_YI      = 256,
  parameter int COLS         = 6,
  parameter int ROWS         = 4,
  parameter int CELL_W       = 100,
  parameter int CELL_H       = 100,
  parameter int LINE_W       = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int WRAP         = 1
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [10:0] hc_visible,
  input  logic [10:0] vc_visible,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        in_grid,
  output logic        lines,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  output logic        on_cursor,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y
);

  // Grid extent: last pixel column and last line that belong to the grid.
  localparam int XF = GRID_XI + COLS * CELL_W;
  localparam int YF = GRID_YI + ROWS * CELL_H;

  localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]   X_FIRST    = 11'(GRID_XI + 1);
  localparam logic [10:0]   X_LAST     = 11'(XF);
  localparam logic [10:0]   X_EDGE     = 11'(XF - LINE_W);
  localparam logic [10:0]   Y_FIRST    = 11'(GRID_YI + 1);
  localparam logic [10:0]   Y_LAST     = 11'(YF);
  localparam logic [10:0]   Y_EDGE     = 11'(YF - LINE_W);
  localparam logic [XW-1:0] X_OFF_MAX  = XW'(CELL_W - 1);
  localparam logic [YW-1:0] Y_OFF_MAX  = YW'(CELL_H - 1);
  localparam logic [XW-1:0] X_LINE     = XW'(LINE_W);
  localparam logic [YW-1:0] Y_LINE     = YW'(LINE_W);
  localparam logic [3:0]    COL_MAX    = 4'(COLS - 1);
  localparam logic [3:0]    ROW_MAX    = 4'(ROWS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Position trackers: offset inside the current cell and the cell index.
  logic [XW-1:0] x_off_q, x_off_d;
  logic [3:0]    col_q,   col_d;
  logic [YW-1:0] y_off_q, y_off_d;
  logic [3:0]    row_q,   row_d;
  logic [10:0]   vc_prev_q, vc_prev_d;

  // Cursor and blink state.
  logic [3:0]    cursor_x_q, cursor_x_d;
  logic [3:0]    cursor_y_q, cursor_y_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  // Registered pixel flags.
  logic          in_grid_q,   in_grid_d;
  logic          lines_q,     lines_d;
  logic [3:0]    cell_x_q,    cell_x_d;
  logic [3:0]    cell_y_q,    cell_y_d;
  logic          on_cursor_q, on_cursor_d;

  logic in_x, in_y, vc_changed, frame_start, move, phase_on;

  // One step toward index 0, wrapping to max_pos or holding at 0.
  function automatic logic [3:0] step_down(input logic [3:0] pos,
                                           input logic [3:0] max_pos);
    if (pos == 4'd0) return (WRAP != 0) ? max_pos : 4'd0;
    return pos - 4'd1;
  endfunction

  // One step toward max_pos, wrapping to 0 or holding at max_pos.
  function automatic logic [3:0] step_up(input logic [3:0] pos,
                                         input logic [3:0] max_pos);
    if (pos == max_pos) return (WRAP != 0) ? 4'd0 : max_pos;
    return pos + 4'd1;
  endfunction

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. A path
    // that leaves a signal unassigned would otherwise infer a latch.
    x_off_d     = x_off_q;
    col_d       = col_q;
    y_off_d     = y_off_q;
    row_d       = row_q;
    vc_prev_d   = vc_visible;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;

    in_x        = (hc_visible >= X_FIRST) && (hc_visible <= X_LAST);
    in_y        = (vc_visible >= Y_FIRST) && (vc_visible <= Y_LAST);
    vc_changed  = (vc_visible != vc_prev_q);
    // A new frame begins when the line count drops from visible to blanking.
    frame_start = (vc_prev_q != 11'd0) && (vc_visible == 11'd0);
    move        = btn_up || btn_down || btn_left || btn_right;
    phase_on    = (BLINK_FRAMES == 0) || phase_q;

    // Horizontal tracking. The *_d values describe the current pixel, so the
    // registered flags below reflect it one clock later.
    if (hc_visible == X_FIRST) begin
      x_off_d = '0;
      col_d   = 4'd0;
    end else if (in_x) begin
      if (x_off_q == X_OFF_MAX) begin
        x_off_d = '0;
        col_d   = col_q + 4'd1;
      end else begin
        x_off_d = x_off_q + XW'(1);
      end
    end

    // Vertical tracking advances once per new line, not once per pixel.
    if ((vc_visible == Y_FIRST) && vc_changed) begin
      y_off_d = '0;
      row_d   = 4'd0;
    end else if (in_y && vc_changed) begin
      if (y_off_q == Y_OFF_MAX) begin
        y_off_d = '0;
        row_d   = row_q + 4'd1;
      end else begin
        y_off_d = y_off_q + YW'(1);
      end
    end

    in_grid_d   = in_x && in_y;
    // The outer frame's right and bottom edges are thickened inward, so the
    // last LINE_W pixels of the final column and row also count as lines.
    lines_d     = in_grid_d && ((x_off_d < X_LINE) || (y_off_d < Y_LINE) ||
                                (hc_visible > X_EDGE) || (vc_visible > Y_EDGE));
    cell_x_d    = in_grid_d ? col_d : 4'd0;
    cell_y_d    = in_grid_d ? row_d : 4'd0;
    on_cursor_d = in_grid_d && !lines_d && (col_d == cursor_x_q) &&
                  (row_d == cursor_y_q) && phase_on;

    // One move per clock. Lower-priority pulses in the same clock are dropped.
    if (btn_up) begin
      cursor_y_d = step_down(cursor_y_q, ROW_MAX);
    end else if (btn_down) begin
      cursor_y_d = step_up(cursor_y_q, ROW_MAX);
    end else if (btn_left) begin
      cursor_x_d = step_down(cursor_x_q, COL_MAX);
    end else if (btn_right) begin
      cursor_x_d = step_up(cursor_x_q, COL_MAX);
    end

    // A move restarts the blink so the cursor is visible where it lands.
    // A move in the same clock as a frame start takes precedence.
    if (move) begin
      frame_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_start && (BLINK_FRAMES != 0)) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, whatever the order in
  // which the statements appear.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      x_off_q     <= '0;
      col_q       <= 4'd0;
      y_off_q     <= '0;
      row_q       <= 4'd0;
      vc_prev_q   <= 11'd0;
      cursor_x_q  <= 4'd0;
      cursor_y_q  <= 4'd0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
      in_grid_q   <= 1'b0;
      lines_q     <= 1'b0;
      cell_x_q    <= 4'd0;
      cell_y_q    <= 4'd0;
      on_cursor_q <= 1'b0;
    end else begin
      x_off_q     <= x_off_d;
      col_q       <= col_d;
      y_off_q     <= y_off_d;
      row_q       <= row_d;
      vc_prev_q   <= vc_prev_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      in_grid_q   <= in_grid_d;
      lines_q     <= lines_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      on_cursor_q <= on_cursor_d;
    end
  end

  assign in_grid   = in_grid_q;
  assign lines     = lines_q;
  assign cell_x    = cell_x_q;
  assign cell_y    = cell_y_q;
  assign on_cursor = on_cursor_q;
  assign cursor_x  = cursor_x_q;
  assign cursor_y  = cursor_y_q;

endmodule

// File: tb/tb_grid_cursor_template.sv
// -----------------------------------------------------------------------------
// tb_grid_cursor_template
//
// Four grid_cursor_template instances share one pixel/button stream:
//   0: defaults
//   1: WRAP=0
//   2: BLINK_FRAMES=2
//   3: 8x3 grid of 50x80 cells, LINE_W=1, BLINK_FRAMES=0
// Each output is compared with an arithmetic reference model. The model takes
// the cell index and offset from division and modulo on hc/vc, and derives
// the blink phase from the number of frames since the last move or reset.
//
// A frame is compressed to keep the run short. Only lines 255..658 are
// presented. Most lines carry a short burst of pixels starting just before
// the grid's left edge. Selected lines carry the full grid width.
// -----------------------------------------------------------------------------
module tb_grid_cursor_template;

  localparam int ND = 4;

  typedef struct packed {
    int xi; int yi; int cols; int rows; int cw; int ch; int lw; int bf; int wrap;
  } cfg_t;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc_visible = '0;
  logic [10:0] vc_visible = '0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;

  logic        in_grid_w[ND];
  logic        lines_w[ND];
  logic        on_w[ND];
  logic [3:0]  cx_w[ND], cy_w[ND], kx_w[ND], ky_w[ND];

  always #5 clk_vga = ~clk_vga;

  grid_cursor_template u_def (
    .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_grid(in_grid_w[0]), .lines(lines_w[0]), .cell_x(cx_w[0]), .cell_y(cy_w[0]),
    .on_cursor(on_w[0]), .cursor_x(kx_w[0]), .cursor_y(ky_w[0]));

  grid_cursor_template #(.WRAP(0)) u_sat (
    .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_grid(in_grid_w[1]), .lines(lines_w[1]), .cell_x(cx_w[1]), .cell_y(cy_w[1]),
    .on_cursor(on_w[1]), .cursor_x(kx_w[1]), .cursor_y(ky_w[1]));

  grid_cursor_template #(.BLINK_FRAMES(2)) u_blink (
    .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_grid(in_grid_w[2]), .lines(lines_w[2]), .cell_x(cx_w[2]), .cell_y(cy_w[2]),
    .on_cursor(on_w[2]), .cursor_x(kx_w[2]), .cursor_y(ky_w[2]));

  grid_cursor_template #(.COLS(8), .ROWS(3), .CELL_W(50), .CELL_H(80), .LINE_W(1),
                         .BLINK_FRAMES(0)) u_alt (
    .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_grid(in_grid_w[3]), .lines(lines_w[3]), .cell_x(cx_w[3]), .cell_y(cy_w[3]),
    .on_cursor(on_w[3]), .cursor_x(kx_w[3]), .cursor_y(ky_w[3]));

  cfg_t cfg[ND];

  // Reference model state.
  int   m_cx[ND], m_cy[ND], m_k[ND];
  int   m_prev_vc = 0;
  bit   synced = 1'b0;
  logic exp_in[ND];
  int   exp_cx[ND];
  bit   exp_valid = 1'b0;

  int tests = 0;
  int fails = 0;

  // Stimulus control.
  logic [3:0] btn_req = 4'b0;
  bit         rand_btn = 1'b0;
  int         press_line = -1;
  logic [3:0] press_mask = 4'b0;
  int         pin_x = 0, pin_y = 0, pin_exp = -1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t hc=%0d vc=%0d)",
               name, actual, expected, $time, hc_visible, vc_visible);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model step: runs 2 time units after each rising edge. The registered
  // outputs then describe the inputs that edge sampled, and those inputs are
  // still on the bus.
  // ---------------------------------------------------------------------------
  task automatic step();
    int h, v, xf, yf, col, row, xo, yo;
    bit ig, ln, oc, ph, fs, mv;
    h = int'(hc_visible);
    v = int'(vc_visible);

    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        m_cx[d] = 0; m_cy[d] = 0; m_k[d] = 0;
        exp_in[d] = 1'b0; exp_cx[d] = 0;
        check($sformatf("rst_in_grid[%0d]", d), 32'(in_grid_w[d]), 0);
        check($sformatf("rst_lines[%0d]", d), 32'(lines_w[d]), 0);
        check($sformatf("rst_cell_x[%0d]", d), 32'(cx_w[d]), 0);
        check($sformatf("rst_cell_y[%0d]", d), 32'(cy_w[d]), 0);
        check($sformatf("rst_on_cursor[%0d]", d), 32'(on_w[d]), 0);
        check($sformatf("rst_cursor_x[%0d]", d), 32'(kx_w[d]), 0);
        check($sformatf("rst_cursor_y[%0d]", d), 32'(ky_w[d]), 0);
      end
      m_prev_vc = 0;
      synced = 1'b0;
      exp_valid = 1'b1;
      return;
    end

    // Pixel tracking is trustworthy from the first blanking line onward.
    if (v == 0) synced = 1'b1;
    fs = (m_prev_vc != 0) && (v == 0);
    mv = btn_up || btn_down || btn_left || btn_right;

    for (int d = 0; d < ND; d++) begin
      xf = cfg[d].xi + cfg[d].cols * cfg[d].cw;
      yf = cfg[d].yi + cfg[d].rows * cfg[d].ch;
      ig = (h > cfg[d].xi) && (h <= xf) && (v > cfg[d].yi) && (v <= yf);
      col = 0; row = 0; xo = 0; yo = 0;
      if (ig) begin
        col = (h - cfg[d].xi - 1) / cfg[d].cw;
        xo  = (h - cfg[d].xi - 1) % cfg[d].cw;
        row = (v - cfg[d].yi - 1) / cfg[d].ch;
        yo  = (v - cfg[d].yi - 1) % cfg[d].ch;
      end
      ln = ig && (xo < cfg[d].lw || yo < cfg[d].lw ||
                  h > xf - cfg[d].lw || v > yf - cfg[d].lw);
      ph = (cfg[d].bf == 0) || (((m_k[d] / cfg[d].bf) % 2) == 0);
      oc = ig && !ln && (col == m_cx[d]) && (row == m_cy[d]) && ph;

      exp_in[d] = ig;
      exp_cx[d] = col;
      check($sformatf("in_grid[%0d]", d), 32'(in_grid_w[d]), 32'(ig));
      if (synced) begin
        check($sformatf("lines[%0d]", d), 32'(lines_w[d]), 32'(ln));
        check($sformatf("cell_x[%0d]", d), 32'(cx_w[d]), 32'(col));
        check($sformatf("cell_y[%0d]", d), 32'(cy_w[d]), 32'(row));
        check($sformatf("on_cursor[%0d]", d), 32'(on_w[d]), 32'(oc));
      end

      // Cursor update for this edge; the outputs already show the new value.
      if (btn_up)
        m_cy[d] = (m_cy[d] == 0) ? (cfg[d].wrap != 0 ? cfg[d].rows - 1 : 0) : m_cy[d] - 1;
      else if (btn_down)
        m_cy[d] = (m_cy[d] == cfg[d].rows - 1) ? (cfg[d].wrap != 0 ? 0 : m_cy[d]) : m_cy[d] + 1;
      else if (btn_left)
        m_cx[d] = (m_cx[d] == 0) ? (cfg[d].wrap != 0 ? cfg[d].cols - 1 : 0) : m_cx[d] - 1;
      else if (btn_right)
        m_cx[d] = (m_cx[d] == cfg[d].cols - 1) ? (cfg[d].wrap != 0 ? 0 : m_cx[d]) : m_cx[d] + 1;
      if (mv) m_k[d] = 0;
      else if (fs) m_k[d]++;

      check($sformatf("cursor_x[%0d]", d), 32'(kx_w[d]), 32'(m_cx[d]));
      check($sformatf("cursor_y[%0d]", d), 32'(ky_w[d]), 32'(m_cy[d]));
    end
    exp_valid = synced;
    m_prev_vc = v;

    // Hand-computed anchor points that pin the model itself.
    if (synced) begin
      if (h == 341 && v == 257) begin
        check("pin_first_in_grid", 32'(in_grid_w[0]), 1);
        check("pin_first_lines", 32'(lines_w[0]), 1);
        check("pin_first_cell_x", 32'(cx_w[0]), 0);
        check("pin_first_cell_y", 32'(cy_w[0]), 0);
      end
      if (h == 545 && v == 460) begin
        check("pin_mid_cell_x", 32'(cx_w[0]), 2);
        check("pin_mid_cell_y", 32'(cy_w[0]), 2);
        check("pin_mid_lines", 32'(lines_w[0]), 0);
      end
      if (h == 940 && v == 656) begin
        check("pin_last_cell_x", 32'(cx_w[0]), 5);
        check("pin_last_cell_y", 32'(cy_w[0]), 3);
        check("pin_last_lines", 32'(lines_w[0]), 1);
      end
      if (h == 941 && v == 656) check("pin_right_out", 32'(in_grid_w[0]), 0);
      if (h == 391 && v == 337) begin
        check("pin_alt_cell_x", 32'(cx_w[3]), 1);
        check("pin_alt_cell_y", 32'(cy_w[3]), 1);
        check("pin_alt_lines", 32'(lines_w[3]), 1);
      end
      if (h == 392 && v == 338) begin
        check("pin_alt_in_cell_x", 32'(cx_w[3]), 1);
        check("pin_alt_in_cell_y", 32'(cy_w[3]), 1);
        check("pin_alt_in_lines", 32'(lines_w[3]), 0);
      end
      if (pin_exp >= 0 && h == pin_x && v == pin_y)
        check("pin_blink_on_cursor", 32'(on_w[2]), 32'(pin_exp));
    end
  endtask

  initial forever begin
    @(posedge clk_vga);
    #2;
    step();
  end

  // Latency check. Shortly after the inputs change on the falling edge, the
  // outputs must still describe the previous pixel.
  initial forever begin
    @(negedge clk_vga);
    #2;
    if (rst_n && exp_valid) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("lag_in_grid[%0d]", d), 32'(in_grid_w[d]), 32'(exp_in[d]));
        check($sformatf("lag_cell_x[%0d]", d), 32'(cx_w[d]), 32'(exp_cx[d]));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pix(input int h, input int v);
    @(negedge clk_vga);
    hc_visible = 11'(h);
    vc_visible = 11'(v);
    if (btn_req != 4'b0) begin
      {btn_up, btn_down, btn_left, btn_right} = btn_req;
      btn_req = 4'b0;
    end else if (rand_btn && $urandom_range(0, 47) == 0) begin
      {btn_up, btn_down, btn_left, btn_right} = 4'($urandom_range(1, 15));
    end else begin
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    end
  endtask

  function automatic bit detail(input int v, input bit full);
    if (v == 270 || v == 370) return 1'b1;
    if (full && (v inside {257, 258, 336, 337, 338, 356, 357, 416, 417,
                           460, 496, 497, 656, 657})) return 1'b1;
    return ($urandom_range(0, 399) == 0);
  endfunction

  task automatic line(input int v, input bit d);
    int n;
    pix(0, v);
    if (d) begin
      for (int h = 338; h <= 943; h++) pix(h, v);
    end else begin
      n = $urandom_range(0, 3);
      for (int h = 339; h <= 340 + n; h++) pix(h, v);
    end
  endtask

  task automatic frame(input bit full);
    for (int v = 255; v <= 658; v++) begin
      if (v == press_line) begin
        btn_req = press_mask;
        press_line = -1;
      end
      line(v, detail(v, full));
    end
    repeat (3) pix(0, 0);
  endtask

  task automatic press(input logic [3:0] mask);
    btn_req = mask;
    pix(0, 0);
    @(posedge clk_vga);
    #3;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  int blink_seq[8];
  int right_wrap[6];
  int right_sat[6];

  initial begin
    cfg[0] = '{xi:340, yi:256, cols:6, rows:4, cw:100, ch:100, lw:2, bf:30, wrap:1};
    cfg[1] = '{xi:340, yi:256, cols:6, rows:4, cw:100, ch:100, lw:2, bf:30, wrap:0};
    cfg[2] = '{xi:340, yi:256, cols:6, rows:4, cw:100, ch:100, lw:2, bf:2,  wrap:1};
    cfg[3] = '{xi:340, yi:256, cols:8, rows:3, cw:50,  ch:80,  lw:1, bf:0,  wrap:1};
    blink_seq  = '{1, 1, 0, 0, 1, 1, 0, 1};
    right_wrap = '{1, 2, 3, 4, 5, 0};
    right_sat  = '{1, 2, 3, 4, 5, 5};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk_vga);
    #1;
    check("reset_in_grid", 32'(in_grid_w[0]), 0);
    check("reset_cursor_x", 32'(kx_w[0]), 0);
    check("reset_cursor_y", 32'(ky_w[0]), 0);
    rst_n = 1'b1;

    // Eight frames without buttons, except a btn_down in frame 7 (an off
    // phase). BLINK_FRAMES=2 instance: on, on, off, off, on, on, off, then on
    // again with the cursor one row down.
    for (int f = 0; f < 8; f++) begin
      pin_x   = 360;
      pin_y   = (f == 7) ? 370 : 270;
      pin_exp = blink_seq[f];
      if (f == 6) begin
        press_line = 300;
        press_mask = 4'b0100;
      end
      frame(f == 0);
    end
    pin_exp = -1;
    check("blink_cursor_row", 32'(ky_w[2]), 1);

    // Reset in the middle of a line inside the grid: outputs clear at once.
    for (int v = 255; v <= 399; v++) line(v, 1'b0);
    pix(0, 400);
    for (int h = 338; h <= 500; h++) pix(h, 400);
    @(posedge clk_vga);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("async_rst_in_grid[%0d]", d), 32'(in_grid_w[d]), 0);
      check($sformatf("async_rst_cell_x[%0d]", d), 32'(cx_w[d]), 0);
      check($sformatf("async_rst_cursor_y[%0d]", d), 32'(ky_w[d]), 0);
    end
    for (int h = 501; h <= 943; h++) begin
      pix(h, 400);
      if (h == 505) rst_n = 1'b1;
    end
    for (int v = 401; v <= 658; v++) line(v, 1'b0);
    repeat (3) pix(0, 0);

    // The next frame must match a clean frame.
    frame(1'b1);

    // Cursor walk to the right from column 0.
    for (int i = 0; i < 6; i++) begin
      press(4'b0001);
      check($sformatf("right_wrap_%0d", i), 32'(kx_w[0]), 32'(right_wrap[i]));
      check($sformatf("right_sat_%0d", i), 32'(kx_w[1]), 32'(right_sat[i]));
    end
    // Up from row 0: wraps to the last row, or holds at row 0.
    press(4'b1000);
    check("up_wrap_y", 32'(ky_w[0]), 3);
    check("up_sat_y", 32'(ky_w[1]), 0);
    // Up and left together: only the row moves.
    press(4'b1010);
    check("up_left_wrap_y", 32'(ky_w[0]), 2);
    check("up_left_wrap_x", 32'(kx_w[0]), 0);
    check("up_left_sat_x", 32'(kx_w[1]), 5);
    pix(0, 0);

    // Random button traffic during frames and blanking.
    rand_btn = 1'b1;
    frame(1'b0);
    frame(1'b0);
    repeat (300) pix(0, 0);
    rand_btn = 1'b0;
    repeat (3) pix(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
